seg_scan_scheduler: RTL and testbench

Time-multiplexing scheduler for the 4-digit common-anode seven-segment display. Shares the single segment bus among four digit slots in fixed round-robin, decodes 4-bit hex values, and accepts new display contents through a load handshake committed only at frame boundaries, so a frame never shows mixed old and new data. It sits between the board's display pins and any producer logic, such as the one-second tick and counter logic.

---
 rtl/seg_scan_if.sv | 23 ++
 rtl/seg_scan_scheduler.sv | 164 ++++++++++++++++
 tb/tb_seg_scan_scheduler.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_if.sv
// Load handshake and display pin bundle for seg_scan_scheduler.
// Producer raises load; the data is taken on any clock edge where ready is also 1.
interface seg_scan_if;
  logic        load;
  logic [15:0] load_data;
  logic [3:0]  load_dp;
  logic [3:0]  load_en;
  logic        ready;
  logic [0:6]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  modport master (
    output load, load_data, load_dp, load_en,
    input  ready, seg, dp, an, frame_done
  );

  modport slave (
    input  load, load_data, load_dp, load_en,
    output ready, seg, dp, an, frame_done
  );
endinterface

// File: rtl/seg_scan_scheduler.sv
// Round-robin 4-digit common-anode seven-segment scanner with frame-aligned data commit.
// Optional slot-start blanking is enabled by defining SEG_SCAN_DEADTIME_EN.
module seg_scan_scheduler #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int DEAD_CYC = 64
) (
  input  logic       clk,
  input  logic       arst,
  seg_scan_if.slave  bus
);
  localparam int SLOT_CYC = CLK_HZ / SCAN_HZ;
  localparam int CW       = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SLOT_CYC - 1);
  localparam logic [CW-1:0] DEAD_M1 = CW'(DEAD_CYC - 1);
`ifdef SEG_SCAN_DEADTIME_EN
  localparam bit DT_EN = 1'b1;
`else
  localparam bit DT_EN = 1'b0;
`endif

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   pend_data_q, pend_data_d, act_data_q, act_data_d;
  logic [3:0]    pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [3:0]    pend_en_q, pend_en_d, act_en_q, act_en_d;
  logic          pend_v_q, pend_v_d;
  logic          ready_q, ready_d;
  logic [0:6]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;
  logic          fd_q;
  logic          slot_end, wrap, accept;
  logic [3:0]    nib;
  logic [0:6]    drv_seg;
  logic          drv_dp;
  logic [3:0]    drv_an;

  function automatic logic [0:6] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b0000001;
      4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;
      4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;
      4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;
      4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0000100;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;
      4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;
      default: hex7 = 7'b0111000;
    endcase
  endfunction

  always_comb begin
    slot_end = (cnt_q == CNT_MAX);
    wrap     = slot_end && (idx_q == 2'd3);
    accept   = bus.load && ready_q;
    cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
    idx_d    = slot_end ? idx_q + 2'd1 : idx_q;

    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pend_en_d   = pend_en_q;
    pend_v_d    = pend_v_q;
    act_data_d  = act_data_q;
    act_dp_d    = act_dp_q;
    act_en_d    = act_en_q;
    // ready==~pend_v, so an accept and a commit can never hit the same edge.
    if (wrap && pend_v_q) begin
      act_data_d = pend_data_q;
      act_dp_d   = pend_dp_q;
      act_en_d   = pend_en_q;
      pend_v_d   = 1'b0;
    end
    if (accept) begin
      pend_data_d = bus.load_data;
      pend_dp_d   = bus.load_dp;
      pend_en_d   = bus.load_en;
      pend_v_d    = 1'b1;
    end
    ready_d = ~pend_v_d;
  end

  // Digit drive for the slot being entered, using the set that will be active then.
  always_comb begin
    nib = act_data_d[{idx_d, 2'b00} +: 4];
    if (act_en_d[idx_d]) begin
      drv_an  = ~(4'b0001 << idx_d);
      drv_seg = hex7(nib);
      drv_dp  = ~act_dp_d[idx_d];
    end else begin
      drv_an  = 4'b1111;
      drv_seg = 7'b1111111;
      drv_dp  = 1'b1;
    end
  end

  always_comb begin
    an_d  = an_q;
    seg_d = seg_q;
    dp_d  = dp_q;
    if (slot_end) begin
      if (DT_EN) begin
        an_d  = 4'b1111;
        seg_d = 7'b1111111;
        dp_d  = 1'b1;
      end else begin
        an_d  = drv_an;
        seg_d = drv_seg;
        dp_d  = drv_dp;
      end
    end else if (DT_EN && (cnt_q == DEAD_M1)) begin
      an_d  = drv_an;
      seg_d = drv_seg;
      dp_d  = drv_dp;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      pend_en_q   <= '0;
      pend_v_q    <= 1'b0;
      act_data_q  <= '0;
      act_dp_q    <= '0;
      act_en_q    <= '0;
      ready_q     <= 1'b1;
      seg_q       <= 7'b1111111;
      dp_q        <= 1'b1;
      an_q        <= 4'b1111;
      fd_q        <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      pend_en_q   <= pend_en_d;
      pend_v_q    <= pend_v_d;
      act_data_q  <= act_data_d;
      act_dp_q    <= act_dp_d;
      act_en_q    <= act_en_d;
      ready_q     <= ready_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
      fd_q        <= wrap;
    end
  end

  assign bus.ready      = ready_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Bench for seg_scan_scheduler: SLOT_CYC=10, DEAD_CYC=2; per-cycle frame checks from a queue.
// Expected slot words are literal decode values held in the vector table.
module tb_seg_scan_scheduler;
`ifdef SEG_SCAN_DEADTIME_EN
  localparam int DEAD = 2;
`else
  localparam int DEAD = 0;
`endif
  localparam logic [11:0] BLANK = 12'hFFF;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dpv;
    logic [3:0]  en;
    logic [47:0] slots;  // {slot0, slot1, slot2, slot3}, each {an, seg a..g, dp}
  } vec_t;

  logic clk = 1'b0;
  logic arst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  vec_t tbl[7];
  logic [13:0] exp_q[$];

  logic [47:0] m_act, m_pend;
  logic        m_pv, m_ready;

  seg_scan_if bus();

  seg_scan_scheduler #(.CLK_HZ(1000), .SCAN_HZ(100), .DEAD_CYC(2)) dut (
    .clk(clk),
    .arst(arst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] sl(input logic [3:0] an, input logic [6:0] seg, input logic dp);
    return {an, seg, dp};
  endfunction

  function automatic logic [13:0] observed();
    return {bus.ready, bus.frame_done, bus.an, bus.seg, bus.dp};
  endfunction

  task automatic chk(input string name, input logic [13:0] got, input logic [13:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_wrap();
    if (m_pv) begin
      m_act   = m_pend;
      m_pv    = 1'b0;
      m_ready = 1'b1;
    end
  endtask

  task automatic model_load(input vec_t v);
    if (m_ready) begin
      m_pend  = v.slots;
      m_pv    = 1'b1;
      m_ready = 1'b0;
    end
  endtask

  task automatic drive(input vec_t v);
    bus.load_data = v.data;
    bus.load_dp   = v.dpv;
    bus.load_en   = v.en;
    bus.load      = 1'b1;
  endtask

  task automatic do_load(input vec_t v);
    drive(v);
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    model_load(v);
    chk("ready_after_load", {13'b0, bus.ready}, {13'b0, m_ready});
  endtask

  // Released from reset at a negedge: the whole first frame is blank, wrap at edge 40.
  task automatic release_check();
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      chk("first_frame", observed(), {1'b1, (n == 40), BLANK});
    end
    model_wrap();
  endtask

  task automatic skip_wrap();
    @(negedge clk);
    chk("wrap_pulse", {13'b0, bus.frame_done}, 14'd1);
    model_wrap();
  endtask

  task automatic check_frame(input bit wrap_ld, input vec_t wv);
    bit found = 1'b0;
    for (int t = 0; t < 100 && !found; t++) begin
      @(negedge clk);
      found = bus.frame_done;
    end
    if (!found) begin
      chk("frame_timeout", 14'd0, 14'd1);
      return;
    end
    model_wrap();
    if (wrap_ld) model_load(wv);
    for (int k = 0; k < 40; k++) begin
      int s = k / 10;
      int c = k % 10;
      logic [11:0] sw = (c < DEAD) ? BLANK : m_act[47 - 12*s -: 12];
      exp_q.push_back({m_ready, (k == 0), sw});
    end
    for (int k = 0; k < 40; k++) begin
      if (k != 0) @(negedge clk);
      chk("frame_cycle", observed(), exp_q.pop_front());
    end
  endtask

  initial begin
    bus.load = 1'b0;
    bus.load_data = '0;
    bus.load_dp = '0;
    bus.load_en = '0;
    m_act = {4{BLANK}};
    m_pend = '0;
    m_pv = 1'b0;
    m_ready = 1'b1;

    tbl[0] = '{16'h1234, 4'b0100, 4'b1111, {sl(4'b1110, 7'b1001100, 1'b1), sl(4'b1101, 7'b0000110, 1'b1),
                                            sl(4'b1011, 7'b0010010, 1'b0), sl(4'b0111, 7'b1001111, 1'b1)}};
    tbl[1] = '{16'hFFFF, 4'b0000, 4'b1111, {sl(4'b1110, 7'b0111000, 1'b1), sl(4'b1101, 7'b0111000, 1'b1),
                                            sl(4'b1011, 7'b0111000, 1'b1), sl(4'b0111, 7'b0111000, 1'b1)}};
    tbl[2] = '{16'h8888, 4'b0000, 4'b1111, {sl(4'b1110, 7'b0000000, 1'b1), sl(4'b1101, 7'b0000000, 1'b1),
                                            sl(4'b1011, 7'b0000000, 1'b1), sl(4'b0111, 7'b0000000, 1'b1)}};
    tbl[3] = '{16'h5A0C, 4'b1111, 4'b0101, {sl(4'b1110, 7'b0110001, 1'b0), BLANK,
                                            sl(4'b1011, 7'b0001000, 1'b0), BLANK}};
    tbl[4] = '{16'h0967, 4'b1000, 4'b1110, {BLANK, sl(4'b1101, 7'b0100000, 1'b1),
                                            sl(4'b1011, 7'b0000100, 1'b1), sl(4'b0111, 7'b0000001, 1'b0)}};
    tbl[5] = '{16'h5E32, 4'b0010, 4'b1111, {sl(4'b1110, 7'b0010010, 1'b1), sl(4'b1101, 7'b0000110, 1'b0),
                                            sl(4'b1011, 7'b0110000, 1'b1), sl(4'b0111, 7'b0100100, 1'b1)}};
    tbl[6] = '{16'hABCD, 4'b0001, 4'b1111, {sl(4'b1110, 7'b1000010, 1'b0), sl(4'b1101, 7'b0110001, 1'b1),
                                            sl(4'b1011, 7'b1100000, 1'b1), sl(4'b0111, 7'b0001000, 1'b1)}};

    repeat (3) @(negedge clk);
    chk("in_reset", observed(), {1'b1, 1'b0, BLANK});
    arst = 1'b0;
    release_check();

    do_load(tbl[0]);
    do_load(tbl[1]);  // ready=0, must be ignored
    check_frame(1'b0, tbl[0]);
    skip_wrap();
    do_load(tbl[2]);
    check_frame(1'b0, tbl[0]);

    for (int i = 3; i <= 5; i++) begin
      skip_wrap();
      repeat ($urandom_range(0, 20)) @(negedge clk);
      do_load(tbl[i]);
      check_frame(1'b0, tbl[0]);
    end

    // Load on the exact wrap edge: old data this frame, new data the next.
    drive(tbl[6]);
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    check_frame(1'b1, tbl[6]);
    check_frame(1'b0, tbl[0]);

    // Asynchronous reset mid-slot with a pending load that must be discarded.
    skip_wrap();
    do_load(tbl[2]);
    repeat (13) @(negedge clk);
    @(posedge clk);
    #3;
    arst = 1'b1;
    #1;
    chk("async_reset", observed(), {1'b1, 1'b0, BLANK});
    @(negedge clk);
    arst = 1'b0;
    m_act = {4{BLANK}};
    m_pv = 1'b0;
    m_ready = 1'b1;
    release_check();
    check_frame(1'b0, tbl[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end
endmodule
